ysyx_24100006_exu_ctrl: RTL and testbench
=========================================

YSYX_24100006_EXU_CTRL -- requirements
Module: ysyx_24100006_exu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have parameter LAT, default 1, giving the number of EXEC cycles per operation; legal range is 1..15.
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  IDU offers an instruction
- in_ready  out  1  block accepts the IDU instruction
- jump  in  4  Jump class of the offered instruction; nonzero means a control transfer
- irq  in  1  offered instruction raises a trap
- flush  in  1  discard all in-flight work
- alu_en  out  1  capture enable for the ALU result register
- out_valid  out  1  result is available to MEMU
- out_ready  in  1  MEMU accepts the result
- npc_valid  out  1  one-cycle pulse that tells IFU the npc is valid for a redirect
- busy  out  1  state is not IDLE
- stall_cnt  out  32  back-pressure cycle counter (see Configuration)

Function
REQ-004 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-005 The handshake rules SHALL be:
- in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready is 0 while reset is high.
- An accept occurs in a cycle with in_valid && in_ready && !flush.
REQ-006 On an accept, the block SHALL:
- go to EXEC in the next cycle;
- load a 4-bit counter with LAT-1;
- latch redir = (jump!=0) || irq.
REQ-007 In EXEC, the counter SHALL decrement by one each cycle.
REQ-008 alu_en SHALL be 1 only in the EXEC cycle where the counter is 0.
REQ-009 In the EXEC cycle where the counter is 0, the next state SHALL be DONE.
REQ-010 Latency: with an accept at cycle T, out_valid SHALL first be 1 at cycle T+LAT+1.
REQ-011 In DONE, out_valid SHALL be 1 and held stable until out_ready is 1.
REQ-012 When DONE && out_ready, the next state SHALL be:
- EXEC if a new accept occurs in the same cycle (back-to-back, no bubble);
- IDLE otherwise.
REQ-013 npc_valid SHALL be 1 for exactly the first DONE cycle of an operation, and only when redir is latched.
REQ-014 npc_valid SHALL NOT be repeated while DONE is held by back-pressure.
REQ-015 flush SHALL force the next state to IDLE from any state, and it has priority over a simultaneous accept or out_ready.
REQ-016 In the cycle flush is asserted:
- out_valid, alu_en and npc_valid are forced to 0;
- no accept occurs;
- the latched operation is discarded.
REQ-017 busy SHALL be 1 whenever state != IDLE.
REQ-018 In IDLE, out_valid, alu_en and npc_valid SHALL all be 0.

Reset
REQ-019 When reset is sampled high, the block SHALL:
- set state to IDLE;
- clear the counter to 0;
- clear redir to 0;
- clear stall_cnt to 0.
REQ-020 While reset is high, outputs SHALL be: in_ready=0, out_valid=0, alu_en=0, npc_valid=0, busy=0.
REQ-021 If reset is asserted mid-operation (in EXEC or DONE), the operation SHALL be dropped without an out_valid or npc_valid pulse.
REQ-022 Reset SHALL take priority over flush and over a handshake in the same cycle.

Configuration
REQ-023 With macro YSYX_24100006_EXU_STALL_CNT_EN defined, stall_cnt SHALL:
- increment by 1 in each cycle with out_valid && !out_ready;
- saturate at 32'hFFFFFFFF;
- be unaffected by flush.
REQ-024 Without YSYX_24100006_EXU_STALL_CNT_EN, stall_cnt SHALL be a constant 0, no counter register is built, and all other behaviour is unchanged.

Verification
REQ-025 Basic latency: with LAT=1, in_valid=1, jump=0, accept at cycle 5 -> alu_en=1 at cycle 6, out_valid=1 at cycle 7, and npc_valid=0 throughout.
REQ-026 Branch redirect: with LAT=3, jump=4'b0010, accept at cycle 0, out_ready held 0 until cycle 8 -> npc_valid=1 only at cycle 4, out_valid=1 on cycles 4..8, and stall_cnt=4 with the macro defined.
REQ-027 Back-to-back: with LAT=1, in_valid and out_ready tied 1 for 6 cycles -> in_ready=1 on every DONE cycle, and out_valid alternates 0,1,0,1 with no extra idle cycles.
REQ-028 Flush mid-operation: with LAT=4, flush at the second EXEC cycle -> state IDLE on the next cycle, no alu_en after the flush, and no out_valid or npc_valid.
REQ-029 Flush versus accept: flush=1 and in_valid=1 in the same IDLE cycle -> no accept, and busy stays 0.
REQ-030 Reset mid-DONE with irq latched: reset high for 1 cycle -> npc_valid and out_valid are 0 from that cycle on, and stall_cnt=0.

Source files
------------

// File: rtl/ysyx_24100006_exu_ctrl_if.sv
// Handshake bundle between the IDU/MEMU side and the EXU control FSM.
// The master modport is the environment; the slave modport is the EXU controller.
interface ysyx_24100006_exu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  jump;
    logic        irq;
    logic        flush;
    logic        alu_en;
    logic        out_valid;
    logic        out_ready;
    logic        npc_valid;
    logic        busy;
    logic [31:0] stall_cnt;

    modport master (
        output in_valid,
        output jump,
        output irq,
        output flush,
        output out_ready,
        input  in_ready,
        input  alu_en,
        input  out_valid,
        input  npc_valid,
        input  busy,
        input  stall_cnt
    );

    modport slave (
        input  in_valid,
        input  jump,
        input  irq,
        input  flush,
        input  out_ready,
        output in_ready,
        output alu_en,
        output out_valid,
        output npc_valid,
        output busy,
        output stall_cnt
    );
endinterface

// File: rtl/ysyx_24100006_exu_ctrl.sv
// EXU control FSM: sequences one LAT-cycle execute step per accepted instruction.
// Optional back-pressure counter is built only with YSYX_24100006_EXU_STALL_CNT_EN.
//
//   state | meaning
//   IDLE  | no operation held, ready to accept
//   EXEC  | counting down LAT cycles, alu_en on the last one
//   DONE  | result offered to MEMU until out_ready
module ysyx_24100006_exu_ctrl #(
    parameter int LAT = 1
) (
    input logic                    clk,
    input logic                    reset,
    ysyx_24100006_exu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_redir;
    logic       r_first;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_exec_last;
    logic       w_out_valid;
    logic       w_new_redir;

    assign w_in_ready  = !reset && ((r_state == S_IDLE) ||
                                    ((r_state == S_DONE) && bus.out_ready));
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign w_exec_last = (r_state == S_EXEC) && (r_cnt == 4'd0);
    assign w_new_redir = (bus.jump != 4'd0) || bus.irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_redir <= 1'b0;
            r_first <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_redir <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_first <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                        r_cnt   <= LAT_M1;
                        r_redir <= w_new_redir;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        r_first <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        if (w_accept) begin
                            r_state <= S_EXEC;
                            r_cnt   <= LAT_M1;
                            r_redir <= w_new_redir;
                        end else begin
                            r_state <= S_IDLE;
                            r_redir <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_redir <= 1'b0;
                end
            endcase
        end
    end

    // Reset and flush mask every output pulse in the very cycle they are seen.
    assign w_out_valid   = !reset && !bus.flush && (r_state == S_DONE);
    assign bus.out_valid = w_out_valid;
    assign bus.alu_en    = !reset && !bus.flush && w_exec_last;
    assign bus.npc_valid = w_out_valid && r_first && r_redir;
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = !reset && (r_state != S_IDLE);

`ifdef YSYX_24100006_EXU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_24100006_exu_ctrl.sv
// Directed bench for ysyx_24100006_exu_ctrl: three instances with LAT = 1, 3 and 4.
module tb_ysyx_24100006_exu_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef YSYX_24100006_EXU_STALL_CNT_EN
    localparam int STALL_ON = 1;
`else
    localparam int STALL_ON = 0;
`endif

    logic        rst  [3];
    logic        iv   [3];
    logic [3:0]  jmp  [3];
    logic        irq_s[3];
    logic        fl   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ae   [3];
    logic        nv   [3];
    logic        bz   [3];
    logic [31:0] sc   [3];

    ysyx_24100006_exu_ctrl_if bus0 ();
    ysyx_24100006_exu_ctrl_if bus1 ();
    ysyx_24100006_exu_ctrl_if bus2 ();

    assign bus0.in_valid = iv[0];   assign bus0.jump = jmp[0];   assign bus0.irq = irq_s[0];
    assign bus0.flush = fl[0];      assign bus0.out_ready = ordy[0];
    assign ir[0] = bus0.in_ready;   assign ov[0] = bus0.out_valid; assign ae[0] = bus0.alu_en;
    assign nv[0] = bus0.npc_valid;  assign bz[0] = bus0.busy;      assign sc[0] = bus0.stall_cnt;

    assign bus1.in_valid = iv[1];   assign bus1.jump = jmp[1];   assign bus1.irq = irq_s[1];
    assign bus1.flush = fl[1];      assign bus1.out_ready = ordy[1];
    assign ir[1] = bus1.in_ready;   assign ov[1] = bus1.out_valid; assign ae[1] = bus1.alu_en;
    assign nv[1] = bus1.npc_valid;  assign bz[1] = bus1.busy;      assign sc[1] = bus1.stall_cnt;

    assign bus2.in_valid = iv[2];   assign bus2.jump = jmp[2];   assign bus2.irq = irq_s[2];
    assign bus2.flush = fl[2];      assign bus2.out_ready = ordy[2];
    assign ir[2] = bus2.in_ready;   assign ov[2] = bus2.out_valid; assign ae[2] = bus2.alu_en;
    assign nv[2] = bus2.npc_valid;  assign bz[2] = bus2.busy;      assign sc[2] = bus2.stall_cnt;

    ysyx_24100006_exu_ctrl #(.LAT(1)) u_lat1 (.clk(clk), .reset(rst[0]), .bus(bus0));
    ysyx_24100006_exu_ctrl #(.LAT(3)) u_lat3 (.clk(clk), .reset(rst[1]), .bus(bus1));
    ysyx_24100006_exu_ctrl #(.LAT(4)) u_lat4 (.clk(clk), .reset(rst[2]), .bus(bus2));

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [3:0] jmp;
        logic       irq;
        logic       fl;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       e_ae;
        logic       e_nv;
        logic       e_bz;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl[NVEC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then settle to the opposite edge.
    task automatic step(input int d, input logic r, input logic v, input logic [3:0] j,
                        input logic q, input logic f, input logic o);
        @(posedge clk);
        #1;
        rst[d] = r; iv[d] = v; jmp[d] = j; irq_s[d] = q; fl[d] = f; ordy[d] = o;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; iv[i] = 1'b0; jmp[i] = 4'd0; irq_s[i] = 1'b0;
            fl[i] = 1'b0; ordy[i] = 1'b0;
        end

        //           rst   iv    jmp    irq   fl    ordy  ir    ov    ae    nv    bz
        tbl[0]  = '{1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // LAT=1: latency, irq redirect, back-to-back, flush in IDLE and in DONE
        for (int i = 0; i < NVEC; i++) begin
            step(0, tbl[i].rst, tbl[i].iv, tbl[i].jmp, tbl[i].irq, tbl[i].fl, tbl[i].ordy);
            chk($sformatf("v%0d in_ready", i),  32'(ir[0]), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d out_valid", i), 32'(ov[0]), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d alu_en", i),    32'(ae[0]), 32'(tbl[i].e_ae));
            chk($sformatf("v%0d npc_valid", i), 32'(nv[0]), 32'(tbl[i].e_nv));
            chk($sformatf("v%0d busy", i),      32'(bz[0]), 32'(tbl[i].e_bz));
        end
        chk("lat1 stall_cnt", sc[0], (STALL_ON != 0) ? 32'd3 : 32'd0);

        // LAT=3 branch held under back-pressure until cycle 8
        step(1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            step(1, 1'b0, k == 0, 4'b0010, 1'b0, 1'b0, k == 8);
            chk($sformatf("br c%0d npc_valid", k), 32'(nv[1]), 32'(k == 4));
            chk($sformatf("br c%0d out_valid", k), 32'(ov[1]), 32'(k >= 4 && k <= 8));
            chk($sformatf("br c%0d alu_en", k),    32'(ae[1]), 32'(k == 3));
            chk($sformatf("br c%0d in_ready", k),  32'(ir[1]), 32'(k == 0 || k >= 8));
            chk($sformatf("br c%0d busy", k),      32'(bz[1]), 32'(k >= 1 && k <= 8));
        end
        chk("br stall_cnt", sc[1], (STALL_ON != 0) ? 32'd4 : 32'd0);

        // LAT=4 flush on the second EXEC cycle
        step(2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            step(2, 1'b0, k == 0, 4'h0, 1'b0, k == 2, 1'b1);
            chk($sformatf("fl c%0d alu_en", k),    32'(ae[2]), 32'd0);
            chk($sformatf("fl c%0d out_valid", k), 32'(ov[2]), 32'd0);
            chk($sformatf("fl c%0d npc_valid", k), 32'(nv[2]), 32'd0);
            chk($sformatf("fl c%0d busy", k),      32'(bz[2]), 32'(k == 1 || k == 2));
        end

        // LAT=4 irq op, reset for one cycle while DONE is held
        for (int k = 0; k <= 9; k++) begin
            step(2, k == 6, k == 0, 4'h0, k == 0, 1'b0, 1'b0);
            chk($sformatf("rs c%0d npc_valid", k), 32'(nv[2]), 32'(k == 5));
            chk($sformatf("rs c%0d out_valid", k), 32'(ov[2]), 32'(k == 5));
            chk($sformatf("rs c%0d busy", k),      32'(bz[2]), 32'(k >= 1 && k <= 5));
            chk($sformatf("rs c%0d in_ready", k),  32'(ir[2]), 32'(k == 0 || k >= 7));
            if (k == 6) chk("rs stall before reset", sc[2], (STALL_ON != 0) ? 32'd1 : 32'd0);
        end
        chk("rs stall_cnt cleared", sc[2], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
